// File: rtl/mmu_tlb_ram_ctrl.sv
// Round-robin arbiter of two Avalon-MM requesters onto one TLB RAM port.
// Optional full-table flush engine when `MMU_TLB_FLUSH_EN is defined.
module mmu_tlb_ram_ctrl #(
   parameter int unsigned        ADDR_W     = 8,
   parameter int unsigned        DATA_W     = 32,
   parameter int unsigned        BE_W       = 4,
   parameter logic [DATA_W-1:0]  FLUSH_DATA = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic [BE_W-1:0]   m0_byteenable,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic [BE_W-1:0]   m1_byteenable,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
   input  logic              flush_req,
   output logic              flush_busy,
   output logic [ADDR_W-1:0] ram_address,
   output logic [BE_W-1:0]   ram_byteenable,
   output logic              ram_chipselect,
   output logic              ram_write,
   output logic [DATA_W-1:0] ram_writedata,
   input  logic [DATA_W-1:0] ram_readdata
);

   logic [1:0]        rd_req;
   logic [1:0]        wr_req;
   logic [1:0]        pend;
   logic [1:0]        grant;
   logic [1:0]        rdv_reg;
   logic [ADDR_W-1:0] addr_arr  [2];
   logic [BE_W-1:0]   be_arr    [2];
   logic [DATA_W-1:0] wdata_arr [2];
   logic              last_grant_reg;
   logic              flushing;
   logic              active;
   logic              win;
   logic [ADDR_W-1:0] flush_addr;

`ifdef MMU_TLB_FLUSH_EN
   typedef enum logic {IDLE, FLUSH} state_t;
   state_t            state_reg;
   logic [ADDR_W-1:0] fa_reg;

   // Reset lands in FLUSH so the table is cleared after every reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg <= FLUSH;
         fa_reg    <= '0;
      end else begin
         case (state_reg)
            IDLE: if (flush_req) state_reg <= FLUSH;
            FLUSH: begin
               if (fa_reg == '1) begin
                  state_reg <= IDLE;
                  fa_reg    <= '0;
               end else begin
                  fa_reg <= fa_reg + 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign flushing   = (state_reg == FLUSH);
   assign flush_addr = fa_reg;
`else
   logic unused_flush_req;
   assign unused_flush_req = flush_req;
   assign flushing         = 1'b0;
   assign flush_addr       = '0;
`endif

   assign flush_busy = flushing;

   assign rd_req       = {m1_read, m0_read};
   assign wr_req       = {m1_write, m0_write};
   assign addr_arr[0]  = m0_address;
   assign addr_arr[1]  = m1_address;
   assign be_arr[0]    = m0_byteenable;
   assign be_arr[1]    = m1_byteenable;
   assign wdata_arr[0] = m0_writedata;
   assign wdata_arr[1] = m1_writedata;

   assign active = reset_n & ~flushing;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_req
         assign pend[gi]  = rd_req[gi] | wr_req[gi];
         // On a tie, the requester not served last time wins.
         assign grant[gi] = active & pend[gi] &
                            (~pend[1-gi] | (last_grant_reg == (gi == 0)));
      end
   endgenerate

   assign win = grant[1];

   assign m0_waitrequest   = pend[0] & ~grant[0];
   assign m1_waitrequest   = pend[1] & ~grant[1];
   assign m0_readdatavalid = rdv_reg[0];
   assign m1_readdatavalid = rdv_reg[1];
   assign m0_readdata      = ram_readdata;
   assign m1_readdata      = ram_readdata;

   // Flush and requester accesses are mutually exclusive via 'active'.
   assign ram_chipselect = reset_n & (flushing | (|grant));
   assign ram_write      = reset_n & (flushing | (|(grant & wr_req)));
   assign ram_address    = flushing ? flush_addr : addr_arr[win];
   assign ram_byteenable = flushing ? {BE_W{1'b1}} : be_arr[win];
   assign ram_writedata  = flushing ? FLUSH_DATA : wdata_arr[win];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         last_grant_reg <= 1'b1;
         rdv_reg        <= '0;
      end else begin
         rdv_reg <= grant & rd_req;
         if (|grant) last_grant_reg <= grant[1];
      end
   end

endmodule

// File: tb/tb_mmu_tlb_ram_ctrl.sv
// Bench for mmu_tlb_ram_ctrl: directed vectors, a transaction-level model and a
// per-cycle compare process; adapts to `MMU_TLB_FLUSH_EN.
module tb_mmu_tlb_ram_ctrl;

`ifdef MMU_TLB_FLUSH_EN
   localparam bit FLUSH_EN = 1'b1;
`else
   localparam bit FLUSH_EN = 1'b0;
`endif
   localparam logic [31:0] FLUSH_VAL = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [7:0]  m0_address, m1_address;
   logic [3:0]  m0_byteenable, m1_byteenable;
   logic        m0_read, m1_read, m0_write, m1_write;
   logic [31:0] m0_writedata, m1_writedata;
   logic        m0_waitrequest, m1_waitrequest;
   logic [31:0] m0_readdata, m1_readdata;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic        flush_req, flush_busy;
   logic [7:0]  ram_address;
   logic [3:0]  ram_byteenable;
   logic        ram_chipselect, ram_write;
   logic [31:0] ram_writedata, ram_readdata;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mmu_tlb_ram_ctrl dut (
      .clk(clk), .reset_n(reset_n),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
      .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .flush_req(flush_req), .flush_busy(flush_busy),
      .ram_address(ram_address), .ram_byteenable(ram_byteenable),
      .ram_chipselect(ram_chipselect), .ram_write(ram_write),
      .ram_writedata(ram_writedata), .ram_readdata(ram_readdata)
   );

   function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   // Who should win this cycle: -1 none, else requester number.
   function automatic int pick(bit p0, bit p1, int last);
      if (p0 && p1) return 1 - last;
      if (p0) return 0;
      if (p1) return 1;
      return -1;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // RAM port s1: registered address, unregistered q
   logic [31:0] ram_mem [256];
   logic [7:0]  ram_addr_q = 8'h00;
   always @(posedge clk) begin
      if (ram_chipselect) begin
         if (ram_write) ram_mem[ram_address] <= merge(ram_mem[ram_address], ram_writedata, ram_byteenable);
         ram_addr_q <= ram_address;
      end
   end
   assign ram_readdata = ram_mem[ram_addr_q];

   // Reference model: contents seen by requesters, flush progress, pending read
   logic [31:0] ref_mem [256];
   bit          m_flush = 1'b0;
   int          m_left = 256;
   int          m_last = 1;
   bit          m_rv0 = 1'b0, m_rv1 = 1'b0;
   logic [31:0] m_rdata = '0;
   bit          p0_w, p1_w;
   int          g_exp;

   assign p0_w  = m0_read | m0_write;
   assign p1_w  = m1_read | m1_write;
   assign g_exp = m_flush ? -1 : pick(p0_w, p1_w, m_last);

   initial begin
      for (int i = 0; i < 256; i++) begin
         ram_mem[i] = 32'hC0DE_0000 | i;
         ref_mem[i] = 32'hC0DE_0000 | i;
      end
   end

   always @(posedge clk) begin
      if (!reset_n) begin
         m_flush <= FLUSH_EN;
         m_left  <= 256;
         m_last  <= 1;
         m_rv0   <= 1'b0;
         m_rv1   <= 1'b0;
      end else begin
         m_rv0 <= 1'b0;
         m_rv1 <= 1'b0;
         if (m_flush) begin
            ref_mem[256 - m_left] <= FLUSH_VAL;
            if (m_left == 1) begin
               m_flush <= 1'b0;
               m_left  <= 256;
            end else begin
               m_left <= m_left - 1;
            end
         end else begin
            case (g_exp)
               0: begin
                  m_last <= 0;
                  if (m0_write) ref_mem[m0_address] <= merge(ref_mem[m0_address], m0_writedata, m0_byteenable);
                  else begin m_rv0 <= 1'b1; m_rdata <= ref_mem[m0_address]; end
               end
               1: begin
                  m_last <= 1;
                  if (m1_write) ref_mem[m1_address] <= merge(ref_mem[m1_address], m1_writedata, m1_byteenable);
                  else begin m_rv1 <= 1'b1; m_rdata <= ref_mem[m1_address]; end
               end
               default: ;
            endcase
            if (flush_req && FLUSH_EN) m_flush <= 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (!reset_n) begin
         chk("rst_cs", ram_chipselect, 0);
         chk("rst_we", ram_write, 0);
      end else begin
         chk("busy", flush_busy, m_flush);
         chk("rdv0", m0_readdatavalid, m_rv0);
         chk("rdv1", m1_readdatavalid, m_rv1);
         if (m_rv0) chk("rdata0", m0_readdata, m_rdata);
         if (m_rv1) chk("rdata1", m1_readdata, m_rdata);
         if (m_flush) begin
            chk("fl_cs", ram_chipselect, 1);
            chk("fl_we", ram_write, 1);
            chk("fl_addr", ram_address, 256 - m_left);
            chk("fl_be", ram_byteenable, 4'hF);
            chk("fl_wd", ram_writedata, FLUSH_VAL);
            chk("fl_wait0", m0_waitrequest, p0_w);
            chk("fl_wait1", m1_waitrequest, p1_w);
         end else begin
            chk("cs", ram_chipselect, g_exp >= 0);
            chk("wait0", m0_waitrequest, p0_w && g_exp != 0);
            chk("wait1", m1_waitrequest, p1_w && g_exp != 1);
            if (g_exp == 0) begin
               chk("we0", ram_write, m0_write);
               chk("addr0", ram_address, m0_address);
               if (m0_write) chk("wd0", ram_writedata, m0_writedata);
               if (m0_write) chk("be0", ram_byteenable, m0_byteenable);
            end
            if (g_exp == 1) begin
               chk("we1", ram_write, m1_write);
               chk("addr1", ram_address, m1_address);
               if (m1_write) chk("wd1", ram_writedata, m1_writedata);
               if (m1_write) chk("be1", ram_byteenable, m1_byteenable);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_req();
      m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0; flush_req = 0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 400 && flush_busy; i++) @(negedge clk);
      chk("idle_reached", flush_busy, 0);
   endtask

   int acc, cnt;

   initial begin
      reset_n = 0;
      clear_req();
      m0_address = 8'h10; m0_byteenable = 4'hF; m0_writedata = '0;
      m1_address = 8'h00; m1_byteenable = 4'hF; m1_writedata = '0;
      m0_read = 1;
      repeat (3) @(negedge clk);
      chk("rst_rdv0", m0_readdatavalid, 0);

      // Reset release with a read held from cycle 0
      cyc(); reset_n = 1;
      acc = -1; cnt = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (flush_busy) cnt++;
         if (!m0_waitrequest) begin acc = c; break; end
      end
      chk("first_accept_cycle", acc, FLUSH_EN ? 256 : 0);
      chk("reset_flush_len", cnt, FLUSH_EN ? 256 : 0);
      cyc(); m0_read = 0;
      @(negedge clk);
      chk("first_rdv", m0_readdatavalid, 1);
      chk("first_rdata", m0_readdata, FLUSH_EN ? 32'h0 : 32'hC0DE_0010);

      // Fresh reset so the first tie goes to m0
      cyc(); reset_n = 0; cyc(); cyc(); reset_n = 1;
      wait_idle();
      cyc();
      m0_address = 8'h01; m0_writedata = 32'h1111_1111; m0_write = 1;
      m1_address = 8'h02; m1_writedata = 32'h2222_2222; m1_write = 1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("tie_addr", ram_address, (i % 2 == 0) ? 1 : 2);
         chk("tie_wait0", m0_waitrequest, i % 2);
         cyc();
      end
      clear_req();

      // Read-after-write on m1
      cyc(); m1_address = 8'h20; m1_writedata = 32'hDEAD_BEEF; m1_byteenable = 4'hF; m1_write = 1;
      cyc(); m1_write = 0; m1_read = 1;
      cyc(); m1_read = 0;
      @(negedge clk);
      chk("raw_rdv1", m1_readdatavalid, 1);
      chk("raw_rdata", m1_readdata, 32'hDEAD_BEEF);
      chk("raw_rdv0", m0_readdatavalid, 0);

      // Partial write
      cyc(); m0_address = 8'h30; m0_writedata = 32'hFFFF_FFFF; m0_byteenable = 4'hF; m0_write = 1;
      cyc(); m0_writedata = 32'h0000_0000; m0_byteenable = 4'h3;
      cyc(); m0_write = 0; m0_read = 1;
      cyc(); m0_read = 0;
      @(negedge clk);
      chk("part_rdv", m0_readdatavalid, 1);
      chk("part_rdata", m0_readdata, 32'hFFFF_0000);

      // flush_req alongside a read grant, then a second request at flush cycle 100
      cyc(); m0_read = 1; flush_req = 1;
      @(negedge clk);
      chk("flreq_grant", m0_waitrequest, 0);
      cyc(); m0_read = 0; flush_req = 0;
      @(negedge clk);
      chk("flreq_rdv", m0_readdatavalid, 1);
      chk("flreq_rdata", m0_readdata, 32'hFFFF_0000);
      cnt = 0;
      for (int i = 0; i < 400 && flush_busy; i++) begin
         cnt++;
         cyc(); flush_req = (i + 1 == 100);
         @(negedge clk);
      end
      flush_req = 0;
      chk("flush_len", cnt, FLUSH_EN ? 256 : 0);
      cyc(); m0_address = 8'h30; m0_read = 1;
      cyc(); m0_read = 0;
      @(negedge clk);
      chk("post_flush_rdata", m0_readdata, FLUSH_EN ? 32'h0 : 32'hFFFF_0000);

      // Reset in the middle of a flush, at fa = 0x80
      cyc(); flush_req = 1;
      cyc(); flush_req = 0;
      repeat (128) cyc();
      reset_n = 0;
      @(negedge clk);
      chk("midrst_cs", ram_chipselect, 0);
      cyc(); cyc(); reset_n = 1;
      @(negedge clk);
      cnt = 0;
      for (int i = 0; i < 400 && flush_busy; i++) begin
         cnt++;
         @(negedge clk);
      end
      chk("midrst_flush_len", cnt, FLUSH_EN ? 256 : 0);
      cyc(); m0_address = 8'h20; m0_read = 1;
      @(negedge clk);
      chk("midrst_accept", m0_waitrequest, 0);
      cyc(); m0_read = 0;
      @(negedge clk);
      chk("midrst_rdata", m0_readdata, FLUSH_EN ? 32'h0 : 32'hDEAD_BEEF);

      cyc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
      $fatal(1);
   end

endmodule
